asteroid_pool: RTL

- Parametrised successor to the fixed four-asteroid group controller.
- Manages NSLOT generic asteroid slots. A hit asteroid splits into two children of the next smaller size; each child is placed in a free slot.
- Once per frame it reports BCD points and per-slot size, and emits spawn commands to the per-slot Asteroid_unit instances (position/phase init).
- Sits between the torpedo/asteroid pixel-enable chain and the score block.

---
 rtl/asteroid_pool.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/asteroid_pool.sv
// asteroid_pool: manages NSLOT asteroid slots. Torpedo hits are collected
// during each frame. On vsync a commit walks the slots one per cycle and
// splits or destroys every asteroid that was hit. It emits spawn commands
// to the per-slot asteroid units and reports the frame's BCD points.
module asteroid_pool #(
    parameter int          NSLOT = 8,
    parameter int          T_NUM = 4,
    parameter logic [15:0] PTS_L = 16'h0020,
    parameter logic [15:0] PTS_M = 16'h0050,
    parameter logic [15:0] PTS_S = 16'h0100,
    localparam int         IW    = $clog2(NSLOT)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               vsync,
    input  logic               new_level,
    input  logic               game_continue,
    input  logic [NSLOT-1:0]   asteroid_en,
    input  logic [T_NUM-1:0]   torpedo_en,
    output logic [T_NUM-1:0]   torpedo_hit,
    output logic [2*NSLOT-1:0] slot_size,
    output logic               spawn_valid,
    output logic [IW-1:0]      spawn_slot,
    output logic [IW-1:0]      spawn_parent,
    output logic               spawn_random,
    output logic               points_valid,
    output logic [15:0]        points_bcd,
    output logic               busy
);

    localparam logic [IW-1:0] LAST = IW'(NSLOT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t         state, state_nx;
    logic [1:0]     size_q [NSLOT];
    logic [NSLOT-1:0] active, new_hits, hit_acc, hit_frame;
    logic [IW-1:0]  idx, stall_slot, free_idx;
    logic           stall, free_found, new_level_pend;
    logic [15:0]    pts, pts_add;
    logic [1:0]     cur_size;
    logic           do_split, do_kill, scan_advance, restart;

    // Four-digit BCD addition that saturates at 9999 on overflow.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] sum;
        logic [4:0]  d;
        logic        carry;
        carry = 1'b0;
        sum   = '0;
        for (int k = 0; k < 4; k++) begin
            d = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0, carry};
            if (d > 5'd9) begin
                d     = d + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*k +: 4] = d[3:0];
        end
        return carry ? 16'h9999 : sum;
    endfunction

    // Slot occupancy, hit detection and the lowest free slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        active     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NSLOT; i++) begin
            active[i] = (size_q[i] != 2'd0);
        end
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (size_q[i] == 2'd0) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        new_hits    = asteroid_en & active & {NSLOT{|torpedo_en}};
        torpedo_hit = torpedo_en & {T_NUM{|(asteroid_en & active)}};
    end

    // Decode of the slot under scan. A stall cycle only issues the second child's spawn.
    always_comb begin
        cur_size     = size_q[idx];
        do_kill      = (state == SCAN) && !stall && hit_frame[idx] && (cur_size == 2'd1);
        do_split     = (state == SCAN) && !stall && hit_frame[idx] && (cur_size >= 2'd2);
        pts_add      = do_split ? ((cur_size == 2'd3) ? PTS_L : PTS_M) : PTS_S;
        scan_advance = stall || !(do_split && free_found);
        restart      = (state == FINISH) && (new_level_pend || !(|active));
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vsync) state_nx = SCAN;
            SCAN:    if (scan_advance && (idx == LAST)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy         = (state != IDLE);
        points_valid = (state == FINISH);
        points_bcd   = (state == FINISH) ? pts : 16'h0000;
        spawn_valid  = 1'b0;
        spawn_slot   = '0;
        spawn_parent = '0;
        spawn_random = 1'b0;
        if (state == SCAN && (stall || do_split)) begin
            spawn_valid  = 1'b1;
            spawn_slot   = stall ? stall_slot : idx;
            spawn_parent = idx;
        end else if (restart) begin
            spawn_valid  = 1'b1;
            spawn_random = 1'b1;
        end
    end

    // Slot state, hit accumulation, scan index and points datapath.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: the slot array is reset like any other register because reset defines the starting field.
            for (int i = 0; i < NSLOT; i++) size_q[i] <= (i == 0) ? 2'd3 : 2'd0;
            hit_acc        <= '0;
            hit_frame      <= '0;
            idx            <= '0;
            stall          <= 1'b0;
            stall_slot     <= '0;
            pts            <= '0;
            new_level_pend <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            if (state == IDLE && vsync) hit_acc <= '0;
            else                        hit_acc <= hit_acc | new_hits;

            if (state == FINISH) new_level_pend <= new_level;
            else if (new_level)  new_level_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (vsync) begin
                        hit_frame <= hit_acc;
                        idx       <= '0;
                        pts       <= '0;
                        stall     <= 1'b0;
                    end
                end
                SCAN: begin
                    if ((do_kill || do_split) && game_continue) pts <= bcd_add_sat(pts, pts_add);
                    if (do_kill) size_q[idx] <= 2'd0;
                    if (do_split) begin
                        size_q[idx] <= cur_size - 2'd1;
                        if (free_found) begin
                            size_q[free_idx]    <= cur_size - 2'd1;
                            hit_frame[free_idx] <= 1'b0;
                            stall_slot          <= free_idx;
                        end
                    end
                    stall <= do_split && free_found;
                    if (scan_advance) idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                FINISH: begin
                    if (restart) begin
                        for (int i = 0; i < NSLOT; i++) size_q[i] <= (i == 0) ? 2'd3 : 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten slot sizes for the output bus.
    always_comb begin
        slot_size = '0;
        for (int i = 0; i < NSLOT; i++) slot_size[2*i +: 2] = size_q[i];
    end

endmodule
